// File: rtl/cart_banked_bridge.sv
// Banked cartridge/SRAM bridge: maps the 6502 S4/S5 windows onto a larger SRAM through per-window bank
// registers, exposes a D5E8-D5EF control page, and shares the SRAM with an auto-incrementing uC port.
module cart_banked_bridge #(
    parameter int RAM_ADDR_W    = 17,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fi2,
    input  logic                  cart_s4,
    input  logic                  cart_s5,
    input  logic                  cart_rw,
    input  logic                  cart_cctl,
    input  logic [12:0]           cart_addr,
    input  logic [7:0]            cart_din,
    output logic [7:0]            cart_dout,
    output logic                  cart_dout_en,
    output logic                  cart_rd4,
    output logic                  cart_rd5,
    input  logic                  cart_write_enable,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    input  logic [7:0]            uc_din,
    output logic [7:0]            uc_dout,
    input  logic                  uc_read,
    input  logic                  uc_write,
    input  logic                  uc_set_lo,
    input  logic                  uc_set_hi,
    input  logic                  uc_set_ext,
    output logic                  uc_ack
);
    localparam int BANK_W = RAM_ADDR_W - 13;
    localparam int KW     = $clog2(ACCESS_CYCLES);
    localparam logic [KW-1:0] K_LAST  = KW'(ACCESS_CYCLES - 1);
    localparam logic [KW-1:0] K_SAMP  = KW'(ACCESS_CYCLES - 2);
    localparam logic [KW-1:0] K_WE_ON = KW'(ACCESS_CYCLES / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_CART_RD, S_CART_WR, S_CTL_WR, S_UC_RD, S_UC_WR} state_t;

    state_t                r_state;
    logic [KW-1:0]         r_k;
    logic                  r_fi2_m, r_fi2_s, r_fi2_d, r_evt, r_pend;
    logic                  r_s4, r_s5, r_rw, r_cctl;
    logic [12:0]           r_addr;
    logic [BANK_W-1:0]     r_bank4, r_bank5;
    logic [1:0]            r_rd_en;
    logic                  r_rd4, r_rd5, r_uc_ack, r_oe_n, r_we_n;
    logic [RAM_ADDR_W-1:0] r_uc_addr, r_hold_val, r_hold_msk, r_ram_addr;
    logic [7:0]            r_ram_dout, r_cart_dout, r_uc_dout;

    logic                  w_rise, w_fall, w_win, w_ctl, w_sel, w_go;
    logic [RAM_ADDR_W-1:0] w_cart_addr, w_live_msk, w_live_val, w_all_msk, w_ua;
    logic [7:0]            w_ctl_rdata;

    assign w_rise      = r_fi2_s & ~r_fi2_d;
    assign w_fall      = ~r_fi2_s & r_fi2_d;
    assign w_win       = r_s4 ^ r_s5;
    assign w_ctl       = ~r_cctl & (r_addr[7:3] == 5'b11101);
    assign w_sel       = w_win | w_ctl;
    assign w_go        = r_evt | r_pend;
    assign w_cart_addr = {(r_s4 ? r_bank5 : r_bank4), r_addr};

    assign cart_dout_en = w_sel & r_rw & fi2;
    assign cart_dout    = r_cart_dout;
    assign cart_rd4     = r_rd4;
    assign cart_rd5     = r_rd5;
    assign ram_addr     = r_ram_addr;
    assign ram_dout     = r_ram_dout;
    assign ram_oe_n     = r_oe_n;
    assign ram_we_n     = r_we_n;
    assign uc_dout      = r_uc_dout;
    assign uc_ack       = r_uc_ack;

    // fi2 synchroniser, edge event and CPU bus capture on each phi2 rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fi2_m <= 1'b0;
            r_fi2_s <= 1'b0;
            r_fi2_d <= 1'b0;
            r_evt   <= 1'b0;
            r_s4    <= 1'b1;
            r_s5    <= 1'b1;
            r_rw    <= 1'b1;
            r_cctl  <= 1'b1;
            r_addr  <= 13'h0000;
        end else begin
            r_fi2_m <= fi2;
            r_fi2_s <= r_fi2_m;
            r_fi2_d <= r_fi2_s;
            r_evt   <= w_rise;
            if (w_rise) begin
                r_s4   <= cart_s4;
                r_s5   <= cart_s5;
                r_rw   <= cart_rw;
                r_cctl <= cart_cctl;
                r_addr <= cart_addr;
            end
        end
    end

    // uC address byte loads: live strobes merge over bytes held while the FSM was busy
    always_comb begin
        w_live_msk = '0;
        w_live_val = r_hold_val;
        for (int b = 0; b < RAM_ADDR_W; b++) begin
            if (b < 8) begin
                w_live_msk[b] = uc_set_lo;
            end else if (b < 16) begin
                w_live_msk[b] = uc_set_hi;
            end else if (b < 24) begin
                w_live_msk[b] = uc_set_ext;
            end else begin
                w_live_msk[b] = 1'b0;
            end
            w_live_val[b] = w_live_msk[b] ? uc_din[3'(b % 8)] : r_hold_val[b];
        end
        w_all_msk = r_hold_msk | w_live_msk;
        w_ua      = (r_uc_addr & ~w_all_msk) | (w_live_val & w_all_msk);
    end

    // Control page read mux
    always_comb begin
        w_ctl_rdata = 8'h00;
        case (r_addr[2:0])
            3'd0:    w_ctl_rdata = 8'(r_bank4);
            3'd1:    w_ctl_rdata = 8'(r_bank5);
            3'd7:    w_ctl_rdata = {r_rd_en, 6'b000000};
            default: w_ctl_rdata = 8'h00;
        endcase
    end

    // Access FSM with registered SRAM strobes, read capture, control registers and uC handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_pend      <= 1'b0;
            r_bank4     <= BANK_W'(0);
            r_bank5     <= BANK_W'(1);
            r_rd_en     <= 2'b11;
            r_rd4       <= 1'b1;
            r_rd5       <= 1'b1;
            r_uc_addr   <= '0;
            r_hold_val  <= '0;
            r_hold_msk  <= '0;
            r_uc_ack    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_dout  <= 8'h00;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_cart_dout <= 8'h00;
            r_uc_dout   <= 8'h00;
        end else begin
            if (r_evt && !w_sel) begin
                {r_rd5, r_rd4} <= r_rd_en;
            end
            if (!uc_read && !uc_write) begin
                r_uc_ack <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_k        <= '0;
                    r_pend     <= 1'b0;
                    r_uc_addr  <= w_ua;
                    r_hold_msk <= '0;
                    if (w_go && !r_rw && w_win && cart_write_enable) begin
                        r_state    <= S_CART_WR;
                        r_ram_addr <= w_cart_addr;
                        r_ram_dout <= cart_din;
                    end else if (w_go && !r_rw && w_ctl) begin
                        r_state <= S_CTL_WR;
                    end else if (w_go && r_rw && w_win) begin
                        r_state    <= S_CART_RD;
                        r_ram_addr <= w_cart_addr;
                        r_oe_n     <= 1'b0;
                    end else if (w_go && r_rw && w_ctl) begin
                        r_cart_dout <= w_ctl_rdata;
                    end else if (w_fall && uc_write && !r_uc_ack) begin
                        r_state    <= S_UC_WR;
                        r_ram_addr <= w_ua;
                        r_ram_dout <= uc_din;
                    end else if (w_fall && uc_read && !r_uc_ack) begin
                        r_state    <= S_UC_RD;
                        r_ram_addr <= w_ua;
                        r_oe_n     <= 1'b0;
                    end
                end
                default: begin
                    r_k        <= r_k + KW'(1);
                    r_hold_val <= w_live_val;
                    r_hold_msk <= w_all_msk;
                    if (r_evt) begin
                        r_pend <= 1'b1;
                    end
                    if (r_k == K_SAMP && r_state == S_CART_RD) begin
                        r_cart_dout <= ram_din;
                    end
                    if (r_k == K_SAMP && r_state == S_UC_RD) begin
                        r_uc_dout <= ram_din;
                    end
                    // we_n spans k = N/2 .. N-2 so address and data settle around both edges
                    if ((r_state == S_CART_WR || r_state == S_UC_WR) && r_k == K_WE_ON) begin
                        r_we_n <= 1'b0;
                    end else if (r_k == K_SAMP) begin
                        r_we_n <= 1'b1;
                    end
                    if (r_k == K_LAST) begin
                        r_state <= S_IDLE;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        if (r_state == S_CTL_WR) begin
                            case (r_addr[2:0])
                                3'd0:    r_bank4 <= cart_din[BANK_W-1:0];
                                3'd1:    r_bank5 <= cart_din[BANK_W-1:0];
                                3'd7:    r_rd_en <= cart_din[7:6];
                                default: r_rd_en <= r_rd_en;
                            endcase
                        end
                        if (r_state == S_UC_RD || r_state == S_UC_WR) begin
                            r_uc_ack  <= 1'b1;
                            r_uc_addr <= r_uc_addr + RAM_ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cart_banked_bridge.sv
// Directed bench for cart_banked_bridge: a behavioural SRAM with a known fill pattern, CPU and uC
// transaction tasks, and hand-computed expectations for each transfer.
module tb_cart_banked_bridge;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset_n, fi2, cart_s4, cart_s5, cart_rw, cart_cctl, cart_write_enable;
    logic [12:0]   cart_addr;
    logic [7:0]    cart_din, cart_dout, ram_din, ram_dout, uc_din, uc_dout;
    logic          cart_dout_en, cart_rd4, cart_rd5, ram_oe_n, ram_we_n;
    logic [AW-1:0] ram_addr;
    logic          uc_read, uc_write, uc_set_lo, uc_set_hi, uc_set_ext, uc_ack;

    logic [7:0]    mem [0:(1<<AW)-1];
    int            n_tests = 0, n_fail = 0;
    int            oe_total = 0, we_total = 0, hi_run = 0, last_gap = 0;
    logic [AW-1:0] last_oe_addr = '0, last_we_addr = '0;
    logic [7:0]    last_we_dout = 8'h00;
    logic          den;
    int            snap;

    always #5 clk = ~clk;
    assign ram_din = mem[ram_addr];

    cart_banked_bridge #(.RAM_ADDR_W(AW), .ACCESS_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .fi2(fi2),
        .cart_s4(cart_s4), .cart_s5(cart_s5), .cart_rw(cart_rw), .cart_cctl(cart_cctl),
        .cart_addr(cart_addr), .cart_din(cart_din), .cart_dout(cart_dout), .cart_dout_en(cart_dout_en),
        .cart_rd4(cart_rd4), .cart_rd5(cart_rd5), .cart_write_enable(cart_write_enable),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .uc_din(uc_din), .uc_dout(uc_dout), .uc_read(uc_read), .uc_write(uc_write),
        .uc_set_lo(uc_set_lo), .uc_set_hi(uc_set_hi), .uc_set_ext(uc_set_ext), .uc_ack(uc_ack)
    );

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'b0000000, a[16]} ^ 8'h3C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        cart_s4 = 1'b1; cart_s5 = 1'b1; cart_rw = 1'b1; cart_cctl = 1'b1;
        cart_addr = 13'h0000; cart_din = 8'h00;
    endtask

    task automatic cpu_cycle(input logic s4, input logic s5, input logic rw, input logic cctl,
                             input logic [12:0] a, input logic [7:0] d, output logic en);
        @(negedge clk);
        cart_s4 = s4; cart_s5 = s5; cart_rw = rw; cart_cctl = cctl; cart_addr = a; cart_din = d;
        fi2 = 1'b1;
        repeat (12) @(negedge clk);
        en  = cart_dout_en;
        fi2 = 1'b0;
        repeat (6) @(negedge clk);
        bus_idle();
    endtask

    task automatic fi2_pulse();
        @(negedge clk);
        fi2 = 1'b1;
        repeat (6) @(negedge clk);
        fi2 = 1'b0;
    endtask

    task automatic uc_load(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] ext);
        @(negedge clk); uc_din = lo;  uc_set_lo  = 1'b1;
        @(negedge clk); uc_set_lo  = 1'b0; uc_din = hi;  uc_set_hi = 1'b1;
        @(negedge clk); uc_set_hi  = 1'b0; uc_din = ext; uc_set_ext = 1'b1;
        @(negedge clk); uc_set_ext = 1'b0;
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        for (int i = 0; i < 60 && uc_ack !== lvl; i++) @(negedge clk);
        check_eq(tag, uc_ack, lvl);
    endtask

    // SRAM model and strobe monitor
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
        forever begin
            @(negedge clk);
            if (ram_oe_n === 1'b0) begin
                if (hi_run > 0) last_gap = hi_run;
                hi_run = 0;
                oe_total++;
                last_oe_addr = ram_addr;
            end else begin
                hi_run++;
            end
            if (ram_we_n === 1'b0) begin
                we_total++;
                last_we_addr = ram_addr;
                last_we_dout = ram_dout;
                mem[ram_addr] = ram_dout;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; fi2 = 1'b0; cart_write_enable = 1'b0;
        bus_idle();
        uc_din = 8'h00; uc_read = 1'b0; uc_write = 1'b0;
        uc_set_lo = 1'b0; uc_set_hi = 1'b0; uc_set_ext = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_rd4", cart_rd4, 1'b1);
        check_eq("rst_rd5", cart_rd5, 1'b1);
        check_eq("rst_ack", uc_ack, 1'b0);
        check_eq("rst_oe_n", ram_oe_n, 1'b1);
        check_eq("rst_we_n", ram_we_n, 1'b1);
        check_eq("rst_dout_en", cart_dout_en, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: bank4 = 3, then S4 read of offset 0
        snap = we_total;
        cpu_cycle(1'b1, 1'b1, 1'b0, 1'b0, 13'h15E8, 8'h03, den);
        check_eq("t1_ctlwr_no_we", we_total - snap, 0);
        snap = oe_total;
        cpu_cycle(1'b0, 1'b1, 1'b1, 1'b1, 13'h0000, 8'h00, den);
        check_eq("t1_oe_cycles", oe_total - snap, 4);
        check_eq("t1_addr", last_oe_addr, 17'h06000);
        check_eq("t1_data", cart_dout, 8'h5C);
        check_eq("t1_dout_en", den, 1'b1);

        // 2: write gating by cart_write_enable
        snap = we_total;
        cpu_cycle(1'b1, 1'b0, 1'b0, 1'b1, 13'h0123, 8'h77, den);
        check_eq("t2_gated_no_we", we_total - snap, 0);
        check_eq("t2_wr_dout_en", den, 1'b0);
        cart_write_enable = 1'b1;
        snap = we_total;
        cpu_cycle(1'b1, 1'b0, 1'b0, 1'b1, 13'h0123, 8'h77, den);
        check_eq("t2_we_cycles", we_total - snap, 1);
        check_eq("t2_we_addr", last_we_addr, 17'h02123);
        check_eq("t2_we_data", last_we_dout, 8'h77);
        cpu_cycle(1'b1, 1'b0, 1'b1, 1'b1, 13'h0123, 8'h00, den);
        check_eq("t2_readback", cart_dout, 8'h77);

        // 3: uC write at top of SRAM, address wraps to 0
        uc_load(8'hFF, 8'hFF, 8'h01);
        uc_din = 8'hA5; uc_write = 1'b1;
        fi2_pulse();
        wait_ack(1'b1, "t3_ack_set");
        check_eq("t3_we_addr", last_we_addr, 17'h1FFFF);
        check_eq("t3_we_data", last_we_dout, 8'hA5);
        check_eq("t3_mem", mem[17'h1FFFF], 8'hA5);
        uc_write = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t3_ack_drop", uc_ack, 1'b0);
        uc_read = 1'b1;
        fi2_pulse();
        wait_ack(1'b1, "t3_rd_ack");
        check_eq("t3_wrap_addr", last_oe_addr, 17'h00000);
        check_eq("t3_rd_data", uc_dout, 8'h3C);
        uc_read = 1'b0;
        wait_ack(1'b0, "t3_rd_ack_drop");

        // 4: rd_en applies only at the next unselected rise; control page reads
        cpu_cycle(1'b1, 1'b1, 1'b0, 1'b0, 13'h15EF, 8'h40, den);
        check_eq("t4_rd5_held", cart_rd5, 1'b1);
        check_eq("t4_rd4_held", cart_rd4, 1'b1);
        cpu_cycle(1'b1, 1'b1, 1'b1, 1'b1, 13'h0000, 8'h00, den);
        check_eq("t4_rd5", cart_rd5, 1'b0);
        check_eq("t4_rd4", cart_rd4, 1'b1);
        check_eq("t4_unsel_dout_en", den, 1'b0);
        cpu_cycle(1'b1, 1'b1, 1'b1, 1'b0, 13'h15EF, 8'h00, den);
        check_eq("t4_rd_D5EF", cart_dout, 8'h40);
        check_eq("t4_ctl_dout_en", den, 1'b1);
        cpu_cycle(1'b1, 1'b1, 1'b1, 1'b0, 13'h15EA, 8'h00, den);
        check_eq("t4_rd_D5EA", cart_dout, 8'h00);
        cpu_cycle(1'b1, 1'b1, 1'b1, 1'b0, 13'h15E9, 8'h00, den);
        check_eq("t4_rd_D5E9", cart_dout, 8'h01);

        // 5: CPU rise during a uC read is held pending and served right after
        uc_load(8'h00, 8'h01, 8'h00);
        @(negedge clk); fi2 = 1'b1;
        repeat (6) @(negedge clk);
        snap = oe_total;
        uc_read = 1'b1;
        cart_s4 = 1'b1; cart_s5 = 1'b0; cart_rw = 1'b1; cart_cctl = 1'b1; cart_addr = 13'h0456;
        fi2 = 1'b0;
        @(negedge clk); fi2 = 1'b1;
        wait_ack(1'b1, "t5_uc_ack");
        check_eq("t5_uc_data", uc_dout, 8'h3D);
        uc_read = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t5_oe_cycles", oe_total - snap, 8);
        check_eq("t5_gap", last_gap, 1);
        check_eq("t5_cart_addr", last_oe_addr, 17'h02456);
        check_eq("t5_cart_data", cart_dout, 8'h4E);
        check_eq("t5_dout_en", cart_dout_en, 1'b1);
        fi2 = 1'b0;
        bus_idle();
        repeat (6) @(negedge clk);

        // 6: reset in the middle of the write strobe
        @(negedge clk);
        cart_s4 = 1'b0; cart_s5 = 1'b1; cart_rw = 1'b0; cart_cctl = 1'b1;
        cart_addr = 13'h0010; cart_din = 8'h99; fi2 = 1'b1;
        for (int i = 0; i < 30 && ram_we_n !== 1'b0; i++) @(negedge clk);
        check_eq("t6_we_low_seen", ram_we_n, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check_eq("t6_we_n", ram_we_n, 1'b1);
        check_eq("t6_oe_n", ram_oe_n, 1'b1);
        check_eq("t6_rd4", cart_rd4, 1'b1);
        check_eq("t6_rd5", cart_rd5, 1'b1);
        check_eq("t6_ack", uc_ack, 1'b0);
        check_eq("t6_cart_dout", cart_dout, 8'h00);
        check_eq("t6_uc_dout", uc_dout, 8'h00);
        check_eq("t6_dout_en", cart_dout_en, 1'b0);
        @(negedge clk);
        fi2 = 1'b0;
        bus_idle();
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        cpu_cycle(1'b1, 1'b1, 1'b1, 1'b0, 13'h15E8, 8'h00, den);
        check_eq("t6_bank4_rst", cart_dout, 8'h00);
        cpu_cycle(1'b1, 1'b1, 1'b1, 1'b0, 13'h15E9, 8'h00, den);
        check_eq("t6_bank5_rst", cart_dout, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
